// File: rtl/fb_pkg.sv
// Purpose: shared frame-buffer definitions for the write and scan-out controllers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fb_pkg;

   // Default panel geometry, shared with the LCD scan-out controller.
   localparam int H_ACTIVE_DEF = 480;
   localparam int V_ACTIVE_DEF = 272;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_WRITE    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Bit positions inside the sticky error vector.
   localparam int ERR_LINE_LEN  = 0;
   localparam int ERR_UNEXP_SOF = 1;

   // Gray8 to RGB565: replicate the top bits of the gray level into each channel.
   function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
      return {g[7:3], g[7:2], g[7:3]};
   endfunction

endpackage

// File: rtl/pix_fmt_rgb565.sv
// Purpose: select between pass-through RGB565 and gray8-to-RGB565 expansion.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports:
//   gray_sel  1 = src_dat[7:0] is a gray8 level, 0 = src_dat is already RGB565
//   src_dat   incoming pixel word
//   rgb_dat   RGB565 pixel word
module pix_fmt_rgb565
   import fb_pkg::*;
(
   input  logic        gray_sel,
   input  logic [15:0] src_dat,
   output logic [15:0] rgb_dat
);

   assign rgb_dat = gray_sel ? gray_to_rgb565(src_dat[7:0]) : src_dat;

endmodule

// File: rtl/fb_wr_ctrl.sv
// Purpose: capture one pixel-stream frame per iStart into the row-major RGB565 frame RAM.
// Latency: RAM write strobe, address and data are registered one cycle after each accepted beat.
// Backpressure: ready is high in WAIT_SOF and WRITE (1 pixel/clock), low in IDLE and DONE.
// Ports:
//   iClk, iRsn              clock, synchronous active-low reset
//   iStart, iGray           arm one frame capture; format select latched with iStart
//   iPixValid/oPixReady     stream handshake; iPixData, iPixSof, iPixEol beat payload
//   oRamWrEn/Addr/Data      frame RAM write port
//   oBusy, oFrameDone, oErr capture armed/active, end-of-frame pulse, sticky errors
module fb_wr_ctrl
   import fb_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = 17
) (
   input  logic              iClk,
   input  logic              iRsn,
   input  logic              iStart,
   input  logic              iGray,
   input  logic              iPixValid,
   input  logic [15:0]       iPixData,
   input  logic              iPixSof,
   input  logic              iPixEol,
   output logic              oPixReady,
   output logic              oRamWrEn,
   output logic [ADDR_W-1:0] oRamWrAddr,
   output logic [15:0]       oRamWrData,
   output logic              oBusy,
   output logic              oFrameDone,
   output logic [1:0]        oErr
);

   localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [X_W-1:0]    X_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

   state_t            state, state_nxt;
   logic [X_W-1:0]    x_q;
   logic [Y_W-1:0]    y_q;
   logic [ADDR_W-1:0] rowbase_q;
   logic              gray_q;
   logic [1:0]        err_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic [15:0]       pix_rgb;
   logic              beat, last_col, last_row;

   pix_fmt_rgb565 u_fmt (
      .gray_sel (gray_q),
      .src_dat  (iPixData),
      .rgb_dat  (pix_rgb)
   );

   assign beat     = iPixValid && oPixReady;
   assign last_col = (x_q == X_LAST);
   assign last_row = (y_q == Y_LAST);

   assign oRamWrEn   = wr_en_q;
   assign oRamWrAddr = wr_addr_q;
   assign oRamWrData = wr_data_q;
   assign oErr       = err_q;

   always_ff @(posedge iClk) begin
      if (!iRsn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      oPixReady  = 1'b0;
      oBusy      = 1'b0;
      oFrameDone = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (iStart) state_nxt = ST_WAIT_SOF;
         end
         ST_WAIT_SOF: begin
            oPixReady = 1'b1;
            oBusy     = 1'b1;
            if (iPixValid && iPixSof) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            oPixReady = 1'b1;
            oBusy     = 1'b1;
            // An SOF beat restarts the frame, so it can never be the final pixel.
            if (iPixValid && !iPixSof && last_col && last_row) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            // The final pixel's write strobe is out in this same cycle.
            oFrameDone = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRsn) begin
         x_q       <= '0;
         y_q       <= '0;
         rowbase_q <= '0;
         gray_q    <= 1'b0;
         err_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if ((state == ST_IDLE) && iStart) begin
            gray_q <= iGray;
            err_q  <= '0;
         end
         if (beat) begin
            if (iPixSof) begin
               // Frame start (or resync on a repeated SOF): pixel lands at address 0.
               wr_en_q   <= 1'b1;
               wr_addr_q <= '0;
               wr_data_q <= pix_rgb;
               x_q       <= X_W'(1);
               y_q       <= '0;
               rowbase_q <= '0;
               if (state == ST_WRITE) err_q[ERR_UNEXP_SOF] <= 1'b1;
            end else if (state == ST_WRITE) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= rowbase_q + ADDR_W'(x_q);
               wr_data_q <= pix_rgb;
               // Short line (EOL early) and long line (no EOL at the last column)
               // both flag the error and resync to the start of the next row.
               if (last_col != iPixEol) err_q[ERR_LINE_LEN] <= 1'b1;
               if (last_col || iPixEol) begin
                  x_q <= '0;
                  // A short line on the last row stays on that row so the
                  // address can never run past the end of the frame.
                  if (!last_row) begin
                     y_q       <= y_q + Y_W'(1);
                     rowbase_q <= rowbase_q + ROW_STEP;
                  end
               end else begin
                  x_q <= x_q + X_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fb_wr_ctrl.sv
module tb_fb_wr_ctrl;

   localparam int H    = 480;
   localparam int V    = 12;
   localparam int AW   = 17;
   localparam int NPIX = H * V;
   localparam int LAST = NPIX - 1;

   logic          iClk = 1'b0;
   logic          iRsn, iStart, iGray, iPixValid, iPixSof, iPixEol;
   logic [15:0]   iPixData;
   logic          oPixReady, oRamWrEn, oBusy, oFrameDone;
   logic [AW-1:0] oRamWrAddr;
   logic [15:0]   oRamWrData;
   logic [1:0]    oErr;

   int n_vec = 0;
   int n_bad = 0;

   // Monitor-owned statistics and RAM image.
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          done_last_cnt = 0;
   int          oob_cnt = 0;
   logic [15:0] mem [0:NPIX-1];

   // Stimulus-owned snapshots.
   int w0, d0, dl0;
   bit gray_special = 1'b0;

   fb_wr_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .iClk       (iClk),
      .iRsn       (iRsn),
      .iStart     (iStart),
      .iGray      (iGray),
      .iPixValid  (iPixValid),
      .iPixData   (iPixData),
      .iPixSof    (iPixSof),
      .iPixEol    (iPixEol),
      .oPixReady  (oPixReady),
      .oRamWrEn   (oRamWrEn),
      .oRamWrAddr (oRamWrAddr),
      .oRamWrData (oRamWrData),
      .oBusy      (oBusy),
      .oFrameDone (oFrameDone),
      .oErr       (oErr)
   );

   always #5 iClk = ~iClk;

   always @(negedge iClk) begin
      if (oRamWrEn === 1'b1) begin
         wr_cnt++;
         if (int'(oRamWrAddr) < NPIX) mem[int'(oRamWrAddr)] = oRamWrData;
         else oob_cnt++;
      end
      if (oFrameDone === 1'b1) begin
         done_cnt++;
         if (oRamWrEn === 1'b1 && int'(oRamWrAddr) == LAST) done_last_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic beat(input logic [15:0] d, input bit sof, input bit eol, input bit st);
      iPixValid = 1'b1;
      iPixData  = d;
      iPixSof   = sof;
      iPixEol   = eol;
      iStart    = st;
      iGray     = st;
      @(posedge iClk);
      #1;
      iPixValid = 1'b0;
      iPixSof   = 1'b0;
      iPixEol   = 1'b0;
      iStart    = 1'b0;
      iGray     = 1'b0;
   endtask

   task automatic start(input bit g);
      iStart = 1'b1;
      iGray  = g;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      iGray  = 1'b0;
   endtask

   function automatic logic [15:0] pix_val(input int a, input logic [15:0] salt);
      if (gray_special && a == 1)   return 16'h00FF;
      if (gray_special && a == 2)   return 16'h0047;
      if (gray_special && a == 963) return 16'hAB80;
      return 16'(a) ^ salt;
   endfunction

   // Rows y0..y1; row short_y carries 470 beats; gaps inserts random idle cycles;
   // start_at raises iStart/iGray alongside the beat with that pixel index.
   task automatic send_rows(input int y0, input int y1, input logic [15:0] salt,
                            input bit sof_first, input int short_y, input bit gaps,
                            input int start_at);
      for (int y = y0; y <= y1; y++) begin
         int nx;
         nx = (y == short_y) ? 470 : H;
         for (int x = 0; x < nx; x++) begin
            int a;
            a = y * H + x;
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            beat(pix_val(a, salt), sof_first && y == y0 && x == 0, x == nx - 1, a == start_at);
         end
      end
   endtask

   task automatic chk_frame(input string tag, input logic [15:0] salt);
      int bad;
      bad = 0;
      for (int k = 0; k < NPIX; k++)
         if (mem[k] !== (16'(k) ^ salt)) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic snap();
      w0  = wr_cnt;
      d0  = done_cnt;
      dl0 = done_last_cnt;
   endtask

   initial begin
      iRsn = 1'b0; iStart = 1'b0; iGray = 1'b0;
      iPixValid = 1'b0; iPixData = '0; iPixSof = 1'b0; iPixEol = 1'b0;
      idle(3);
      chk("rst_ready", oPixReady, 0);
      chk("rst_wren", oRamWrEn, 0);
      chk("rst_addr", oRamWrAddr, 0);
      chk("rst_data", oRamWrData, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oFrameDone, 0);
      chk("rst_err", oErr, 0);
      iRsn = 1'b1;
      idle(2);
      chk("idle_ready", oPixReady, 0);

      // Reset in the middle of row 8.
      snap();
      start(1'b0);
      chk("arm_busy", oBusy, 1);
      chk("arm_ready", oPixReady, 1);
      send_rows(0, 7, 16'h1111, 1'b1, -1, 1'b0, -1);
      for (int x = 0; x < 100; x++) beat(16'(8 * H + x) ^ 16'h1111, 1'b0, 1'b0, 1'b0);
      iRsn = 1'b0;
      idle(1);
      chk("midrst_ready", oPixReady, 0);
      chk("midrst_wren", oRamWrEn, 0);
      chk("midrst_addr", oRamWrAddr, 0);
      chk("midrst_data", oRamWrData, 0);
      chk("midrst_busy", oBusy, 0);
      chk("midrst_done", oFrameDone, 0);
      chk("midrst_err", oErr, 0);
      iRsn = 1'b1;
      idle(4);
      chk("partial_writes", wr_cnt - w0, 8 * H + 100);
      chk("midrst_no_done", done_cnt - d0, 0);

      // Clean RGB565 frame, continuous valid.
      snap();
      start(1'b0);
      send_rows(0, V - 1, 16'h0000, 1'b1, -1, 1'b0, -1);
      chk("clean_done_pulse", oFrameDone, 1);
      chk("clean_done_busy", oBusy, 0);
      chk("clean_done_ready", oPixReady, 0);
      chk("clean_last_addr", oRamWrAddr, LAST);
      idle(1);
      chk("clean_done_one_cycle", oFrameDone, 0);
      chk("clean_writes", wr_cnt - w0, NPIX);
      chk("clean_done_cnt", done_cnt - d0, 1);
      chk("clean_done_with_last", done_last_cnt - dl0, 1);
      chk("clean_err", oErr, 0);
      chk_frame("clean_content", 16'h0000);

      // Gray mode.
      gray_special = 1'b1;
      snap();
      start(1'b1);
      send_rows(0, V - 1, 16'h0000, 1'b1, -1, 1'b0, -1);
      gray_special = 1'b0;
      idle(1);
      chk("gray_963", mem[963], 16'h8410);
      chk("gray_ff", mem[1], 16'hFFFF);
      chk("gray_47", mem[2], 16'h4228);
      chk("gray_writes", wr_cnt - w0, NPIX);
      chk("gray_err", oErr, 0);

      // Junk before SOF, then random valid gaps.
      snap();
      start(1'b0);
      beat(16'hDEAD, 1'b0, 1'b0, 1'b0);
      beat(16'hBEEF, 1'b0, 1'b1, 1'b0);
      beat(16'h0BAD, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("junk_no_write", wr_cnt - w0, 0);
      chk("junk_still_busy", oBusy, 1);
      send_rows(0, V - 1, 16'h3C3C, 1'b1, -1, 1'b1, -1);
      idle(2);
      chk("gaps_writes", wr_cnt - w0, NPIX);
      chk("gaps_done_with_last", done_last_cnt - dl0, 1);
      chk("gaps_err", oErr, 0);
      chk_frame("gaps_content", 16'h3C3C);

      // Short line 5 (470 beats).
      snap();
      start(1'b0);
      send_rows(0, 5, 16'hA5A5, 1'b1, 5, 1'b0, -1);
      chk("short_err_set", oErr, 2'b01);
      send_rows(6, V - 1, 16'hA5A5, 1'b0, -1, 1'b0, -1);
      chk("short_done_pulse", oFrameDone, 1);
      idle(1);
      chk("short_row6_first", mem[2880], 16'(2880) ^ 16'hA5A5);
      chk("short_row5_last", mem[2869], 16'(2869) ^ 16'hA5A5);
      chk("short_row5_untouched", mem[2870], 16'(2870) ^ 16'h3C3C);
      chk("short_writes", wr_cnt - w0, NPIX - 10);
      chk("short_err_sticky", oErr, 2'b01);

      // SOF reasserted at y=10, iStart during WRITE ignored.
      snap();
      start(1'b0);
      send_rows(0, 9, 16'h0F0F, 1'b1, -1, 1'b0, -1);
      chk("presof_err", oErr, 0);
      send_rows(0, V - 1, 16'h7777, 1'b1, -1, 1'b0, 1500);
      chk("resync_done_pulse", oFrameDone, 1);
      chk("resync_err", oErr, 2'b10);
      idle(1);
      chk("resync_writes", wr_cnt - w0, 10 * H + NPIX);
      chk("resync_done_cnt", done_cnt - d0, 1);
      chk_frame("resync_content", 16'h7777);

      // A fresh iStart clears the sticky errors.
      start(1'b0);
      chk("err_cleared", oErr, 0);
      chk("rearm_busy", oBusy, 1);
      chk("no_oob_writes", oob_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_wr_ctrl.md
Name: fb_wr_ctrl

Overview:
Frame-buffer write controller. It sits directly upstream of the LCD scan-out controller and fills the shared 480x272 RGB565 frame RAM that the scan-out controller reads.
- Accepts a valid/ready pixel stream with SOF/EOL markers from the CNN/pixel pipeline.
- Optionally expands 8-bit grayscale to RGB565.
- Writes one frame per iStart into RAM addresses 0..H_ACTIVE*V_ACTIVE-1, row-major.

Parameters:
H_ACTIVE, 480, pixels per line
V_ACTIVE, 272, lines per frame
ADDR_W, 17, RAM address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
iClk  in  1  system clock
iRsn  in  1  reset, synchronous, active-low
iStart  in  1  single-cycle pulse: arm capture of one frame
iGray  in  1  format select: 1 = iPixData[7:0] is gray8, 0 = iPixData is RGB565; sampled on iStart
iPixValid  in  1  stream beat valid
iPixData  in  16  pixel data
iPixSof  in  1  beat is first pixel of frame
iPixEol  in  1  beat is last pixel of a line
oPixReady  out  1  block can accept a beat
oRamWrEn  out  1  RAM write strobe
oRamWrAddr  out  ADDR_W  RAM write address
oRamWrData  out  16  RGB565 write data
oBusy  out  1  capture armed or in progress
oFrameDone  out  1  one-cycle pulse when the frame is complete
oErr  out  2  sticky error flags: [0] line-length mismatch, [1] unexpected SOF; cleared on accepted iStart

Behaviour:
- Reset (iRsn=0 at posedge): state IDLE; all outputs 0; x/y counters, row base and latched iGray cleared. This also applies mid-frame, with no partial-frame completion.
- Transfer occurs when iPixValid && oPixReady. oPixReady = 1 in WAIT_SOF and WRITE, 0 in IDLE and DONE.
- IDLE: iStart=1 -> WAIT_SOF. Latch iGray, clear oErr, oBusy=1 from the next cycle.
- iStart in any other state is ignored.
- WAIT_SOF: beats without SOF are consumed and discarded, with no write. A beat with SOF is written to address 0, x=1, y=0, then -> WRITE.
- WRITE, for each transferred beat:
  - Address = rowbase + x.
  - Beat with SOF: set oErr[1], write to address 0, restart x=1, y=0, rowbase=0.
  - EOL with x==H_ACTIVE-1: write; then x=0, y++, rowbase += H_ACTIVE.
  - EOL with x<H_ACTIVE-1: write, set oErr[0], advance row as above (short line resync).
  - No EOL at x==H_ACTIVE-1: write, set oErr[0], force row advance (long line). Excess beats then land at the start of the next row.
  - Beat at x==H_ACTIVE-1, y==V_ACTIVE-1: write, then -> DONE, regardless of EOL (the EOL check still applies).
- DONE: lasts one cycle. oFrameDone=1 for exactly that cycle. oBusy=0. -> IDLE.
- Write pipeline: one register stage. oRamWrEn/oRamWrAddr/oRamWrData are asserted in the cycle after the transfer, and held 0/last-value-irrelevant when oRamWrEn=0.
- oFrameDone coincides with the last pixel's oRamWrEn. Back-to-back beats give one write per cycle.
- Gray expansion: R = g[7:3], G = g[7:2], B = g[7:3], packed {R,G,B}. RGB565 mode passes iPixData unchanged.
- Address arithmetic: ADDR_W-bit unsigned. rowbase never exceeds (V_ACTIVE-1)*H_ACTIVE; no wrap is possible.
- Throughput: 1 pixel/clock sustained; no backpressure inside WRITE.

Decomposition:
- Shared package fb_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults (shared with the scan-out controller);
  - state encoding IDLE/WAIT_SOF/WRITE/DONE;
  - error bit indices;
  - the gray-to-RGB565 pack function.
- One natural sub-module: pix_fmt_rgb565, the combinational format converter (gray8/RGB565 select). The FSM, counters and write register stay in fb_wr_ctrl.

Test Plan:
- Reset mid-frame (y=100): assert iRsn=0 one cycle -> all outputs 0, state IDLE; no oFrameDone; next iStart captures normally.
- Clean RGB565 frame, 480x272 beats, data = address[15:0], continuous valid:
  - 130560 writes, address k holds data k.
  - oFrameDone with write to address 130559.
  - oErr=0.
- Gray mode, pixel 0x80 at (x=3,y=2) -> write address 963, data 0x8410.
- Three junk beats before SOF, then random valid gaps -> junk discarded, no write before SOF; write count still 130560.
- Line 5 carries only 470 beats with EOL -> oErr[0]=1; line 6 first pixel written at address 2880.
- SOF reasserted at y=10 -> oErr[1]=1, that beat written to address 0; frame completes after a further 130560 beats. iStart during WRITE is ignored (oErr not cleared).
